// File: rtl/lpddr3_iod_ctrl_pkg.sv
// Shared types for the LPDDR3 IOD delay-line sequencers.
package lpddr3_iod_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic DELAY_DIR_INC = 1'b1;

endpackage

// File: rtl/lpddr3_dm_delay_ctrl_if.sv
// Command handshake and status between lane calibration FSM and the DM delay sequencer.
interface lpddr3_dm_delay_ctrl_if #(
  parameter int unsigned TAP_W = 8
);
  import lpddr3_iod_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [TAP_W-1:0] cmd_steps;
  logic             done;
  logic             err;
  logic [TAP_W-1:0] tap;

  modport master (
    output cmd_valid, cmd_op, cmd_steps,
    input  cmd_ready, done, err, tap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_steps,
    output cmd_ready, done, err, tap
  );

endinterface

// File: rtl/lpddr3_iod_step_timer.sv
// Loadable down-counter with terminal count; times LOAD hold and post-MOVE settle windows.
module lpddr3_iod_step_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/lpddr3_dm_delay_ctrl.sv
// Sequencer turning LOAD/INC/DEC commands into spaced IOD delay-line LOAD/MOVE/DIRECTION activity.
module lpddr3_dm_delay_ctrl
  import lpddr3_iod_ctrl_pkg::*;
#(
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAP    = 255,
  parameter int unsigned INIT_TAP   = 1,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned LOAD_CYC   = 2
) (
  input  logic                   fab_clk,
  input  logic                   arst_n,
  lpddr3_dm_delay_ctrl_if.slave  cmd,
  output logic                   delay_line_load,
  output logic                   delay_line_move,
  output logic                   delay_line_direction,
  input  logic                   delay_line_out_of_range
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > LOAD_CYC) ? SETTLE_CYC : LOAD_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [TAP_W-1:0] steps_q, steps_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             move_q, move_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc_c;

  function automatic logic at_limit(input logic dir, input logic [TAP_W-1:0] t);
    return (dir == DELAY_DIR_INC) ? (t == MAX_T) : (t == '0);
  endfunction

  lpddr3_iod_step_timer #(.CNT_W(TMR_W)) u_step_timer (
    .clk      (fab_clk),
    .rst_n    (arst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc_c     (tmr_tc_c)
  );

  // Next-state logic; zero-step and reserved commands pass through MOVE without a pulse
  // so every non-LOAD command spends one decision cycle before FINISH.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    steps_d  = steps_q;
    tap_d    = tap_q;
    dir_d    = dir_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d    = cmd.cmd_op;
          steps_d = cmd.cmd_steps;
          err_d   = 1'b0;
          dir_d   = (cmd.cmd_op == OP_INC) ? DELAY_DIR_INC : ~DELAY_DIR_INC;
          if (cmd.cmd_op == OP_LOAD) begin
            state_d  = ST_LOAD;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOAD_CYC - 1);
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_LOAD: begin
        if (tmr_tc_c) begin
          tap_d   = INIT_T;
          state_d = ST_FINISH;
        end
      end
      ST_MOVE: begin
        if (op_q == OP_RSVD) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (steps_q == '0) begin
          state_d = ST_FINISH;
        end else if (at_limit(dir_q, tap_q)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr_tc_c) begin
          if (delay_line_out_of_range) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            tap_d   = (dir_q == DELAY_DIR_INC) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
            steps_d = steps_q - TAP_W'(1);
            state_d = (steps_q == TAP_W'(1)) ? ST_FINISH : ST_MOVE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_FINISH);
    load_d  = (state_d == ST_LOAD);
    move_d  = (state_d == ST_MOVE) && (op_d != OP_RSVD) && (steps_d != '0)
              && !at_limit(dir_d, tap_d);
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      steps_q <= '0;
      tap_q   <= INIT_T;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      tap_q   <= tap_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      load_q  <= load_d;
      move_q  <= move_d;
    end
  end

  assign cmd.cmd_ready         = ready_q;
  assign cmd.done              = done_q;
  assign cmd.err               = err_q;
  assign cmd.tap               = tap_q;
  assign delay_line_load       = load_q;
  assign delay_line_move       = move_q;
  assign delay_line_direction  = dir_q;

endmodule

// File: tb/tb_lpddr3_dm_delay_ctrl.sv
// Scoreboard bench for lpddr3_dm_delay_ctrl: random and directed commands against a timing model.
module tb_lpddr3_dm_delay_ctrl;
  import lpddr3_iod_ctrl_pkg::*;

  localparam int S    = 4;
  localparam int L    = 2;
  localparam int MAXT = 255;
  localparam int INIT = 1;

  typedef struct {
    int done_off;
    int n_pulses;
    int load_cyc;
    int tap;
    bit err;
    bit dir;
  } exp_t;

  logic fab_clk = 1'b0;
  logic arst_n  = 1'b0;
  logic dl_load, dl_move, dl_dir;
  logic oor = 1'b0;

  lpddr3_dm_delay_ctrl_if #(.TAP_W(8)) cmd_if ();

  lpddr3_dm_delay_ctrl #(
    .TAP_W(8), .MAX_TAP(MAXT), .INIT_TAP(INIT), .SETTLE_CYC(S), .LOAD_CYC(L)
  ) dut (
    .fab_clk                 (fab_clk),
    .arst_n                  (arst_n),
    .cmd                     (cmd_if),
    .delay_line_load         (dl_load),
    .delay_line_move         (dl_move),
    .delay_line_direction    (dl_dir),
    .delay_line_out_of_range (oor)
  );

  always #5 fab_clk = ~fab_clk;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc_cyc = -1000;
  int   inj_k = -1;
  int   model_tap = INIT;
  bit   in_reset = 1'b1;
  bit   mon_busy = 1'b0;
  exp_t sb_q[$];

  always @(posedge fab_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: step-by-step walk of the command using the documented timing rules.
  function automatic exp_t model(input op_e op, input int steps, input int tap0, input int inj);
    exp_t e;
    int t;
    e.dir      = (op == OP_INC);
    e.n_pulses = 0;
    e.load_cyc = 0;
    e.err      = 1'b0;
    e.tap      = tap0;
    e.done_off = 2;
    case (op)
      OP_LOAD: begin e.tap = INIT; e.load_cyc = L; e.done_off = L + 1; end
      OP_RSVD: begin e.err = 1'b1; e.done_off = 2; end
      default: begin
        t = tap0;
        e.done_off = (steps == 0) ? 2 : steps * (S + 1) + 1;
        for (int i = 0; i < steps; i++) begin
          if ((op == OP_INC && t == MAXT) || (op == OP_DEC && t == 0)) begin
            e.err = 1'b1; e.done_off = i * (S + 1) + 2; break;
          end
          e.n_pulses++;
          if (i == inj) begin
            e.err = 1'b1; e.done_off = (i + 1) * (S + 1) + 1; break;
          end
          t = (op == OP_INC) ? t + 1 : t - 1;
        end
        e.tap = t;
      end
    endcase
    return e;
  endfunction

  // OUT_OF_RANGE: scheduled value in sampling cycles, random noise everywhere else.
  initial begin
    int d;
    forever begin
      @(posedge fab_clk); #1;
      d = cyc - acc_cyc;
      if (d > 0 && (d % (S + 1)) == 0) oor = ((d / (S + 1) - 1) == inj_k);
      else oor = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic issue(input op_e op, input int steps, input int inj);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge fab_clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_steps = 8'(steps);
    while (!cmd_if.cmd_ready) begin
      @(negedge fab_clk);
      guard++;
      if (guard > 3000) begin
        $display("FAIL ready_wait: got 0 expected 1 (cycle %0d)", cyc);
        $fatal(1, "ready never returned");
      end
    end
    e = model(op, steps, model_tap, inj);
    acc_cyc   = cyc;
    inj_k     = inj;
    model_tap = e.tap;
    sb_q.push_back(e);
    @(negedge fab_clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = op_e'(2'($urandom_range(0, 3)));
    cmd_if.cmd_steps = 8'($urandom_range(0, 255));
  endtask

  // Monitor: pops the expectation at accept and checks pulses, window and completion.
  initial begin
    exp_t e;
    int   t0, pulses, loads, o;
    bit   just_done;
    t0 = 0; pulses = 0; loads = 0; o = 0; just_done = 1'b0;
    forever begin
      @(negedge fab_clk); #1;
      if (in_reset) begin mon_busy = 1'b0; just_done = 1'b0; continue; end
      if (mon_busy) begin
        o = cyc - t0;
        if (o == 1) chk("err_clear_on_accept", int'(cmd_if.err), 0);
        if (dl_move) begin
          chk("move_time", o, 1 + pulses * (S + 1));
          chk("move_dir", int'(dl_dir), int'(e.dir));
          pulses++;
        end
        if (dl_load) begin
          chk("load_window", int'(o >= 1 && o <= e.load_cyc), 1);
          loads++;
        end
        if (cmd_if.done) begin
          chk("done_time", o, e.done_off);
          chk("done_tap", int'(cmd_if.tap), e.tap);
          chk("done_err", int'(cmd_if.err), int'(e.err));
          chk("pulse_count", pulses, e.n_pulses);
          chk("load_count", loads, e.load_cyc);
          chk("dir_at_done", int'(dl_dir), int'(e.dir));
          chk("ready_low_at_done", int'(cmd_if.cmd_ready), 0);
          mon_busy = 1'b0;
          just_done = 1'b1;
        end else if (o > e.done_off + 2) begin
          chk("done_timeout", o, e.done_off);
          mon_busy = 1'b0;
        end
      end else begin
        if (just_done) chk("ready_after_done", int'(cmd_if.cmd_ready), 1);
        just_done = 1'b0;
        chk("idle_move", int'(dl_move), 0);
        chk("idle_load", int'(dl_load), 0);
        chk("idle_done", int'(cmd_if.done), 0);
      end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          e = sb_q.pop_front();
          t0 = cyc; pulses = 0; loads = 0;
          mon_busy = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, int'(cmd_if.cmd_ready), 1);
    chk({tag, "_tap"},   int'(cmd_if.tap), INIT);
    chk({tag, "_done"},  int'(cmd_if.done), 0);
    chk({tag, "_err"},   int'(cmd_if.err), 0);
    chk({tag, "_load"},  int'(dl_load), 0);
    chk({tag, "_move"},  int'(dl_move), 0);
    chk({tag, "_dir"},   int'(dl_dir), 0);
  endtask

  initial begin
    op_e  op;
    int   steps, inj, guard;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_steps = '0;
    repeat (3) @(negedge fab_clk);
    check_reset_values("rst");
    arst_n = 1'b1;
    @(negedge fab_clk);
    in_reset = 1'b0;
    check_reset_values("idle");

    issue(OP_LOAD, 0, -1);
    issue(OP_INC, 3, -1);
    issue(OP_LOAD, 0, -1);
    issue(OP_INC, 1, -1);
    issue(OP_DEC, 5, -1);
    issue(OP_LOAD, 0, -1);
    issue(OP_INC, 10, 1);
    issue(OP_RSVD, 0, -1);
    issue(OP_DEC, 0, -1);
    issue(OP_LOAD, 0, -1);
    issue(OP_INC, 255, -1);
    issue(OP_INC, 2, -1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge fab_clk);
      op    = op_e'(2'($urandom_range(0, 3)));
      steps = int'($urandom_range(0, 6));
      inj   = (steps > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, steps - 1)) : -1;
      issue(op, steps, inj);
    end

    issue(OP_LOAD, 0, -1);
    issue(OP_INC, 10, -1);
    repeat (7) @(posedge fab_clk);
    #3;
    in_reset = 1'b1;
    arst_n   = 1'b0;
    #1;
    check_reset_values("mid_rst");
    sb_q.delete();
    model_tap = INIT;
    repeat (3) @(negedge fab_clk);
    arst_n = 1'b1;
    @(negedge fab_clk);
    in_reset = 1'b0;

    issue(OP_DEC, 2, -1);
    issue(OP_INC, 3, 0);

    guard = 0;
    while ((mon_busy || sb_q.size() != 0) && guard < 3000) begin
      @(negedge fab_clk);
      guard++;
    end
    chk("drain", int'(mon_busy || sb_q.size() != 0), 0);
    repeat (2) @(negedge fab_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
